vector_memory_arbiter: RTL and testbench

Two-port burst arbiter and sequencer placed in front of the vector data memory (64-bit words, combinational read, write on clock edge). Port 0 serves the vector pipeline's load/store unit; port 1 serves the I/O loader/DMA. It grants one requester at a time in round-robin order. It issues single- or multi-word bursts with auto-incrementing addresses and returns registered read data.

---
 rtl/vector_memory_arbiter.sv | 144 ++++++++++++++
 tb/tb_vector_memory_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_memory_arbiter.sv
// Two-port round-robin burst arbiter in front of the vector data memory.
// Bursts auto-increment the address (wrapping at MEM_SIZE-1) and return registered read data.
module vector_memory_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 19,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned BURST_WIDTH   = 4,
    parameter int unsigned MEM_SIZE      = 2000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [BURST_WIDTH-1:0]   len0,
    input  logic [BURST_WIDTH-1:0]   len1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     done0,
    output logic                     done1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     mem_writeEnable,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_inputData,
    input  logic [DATA_WIDTH-1:0]    mem_outputData
);

    localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [BURST_WIDTH-1:0]   OneBeat  = BURST_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rvalid0_q, rvalid0_d;
    logic                     rvalid1_q, rvalid1_d;

    logic                     in_burst;
    logic                     owner_req;
    logic                     beat;
    logic                     last_beat;
    logic                     pick;
    logic [BURST_WIDTH-1:0]   len_sel;

    always_comb begin
        in_burst        = (state_q == StBurst);
        owner_req       = owner_q ? req1 : req0;
        // A beat happens only while the owner keeps its request up; a drop aborts the burst.
        beat            = in_burst & owner_req;
        last_beat       = beat & (count_q == OneBeat);
        gnt0            = beat & ~owner_q;
        gnt1            = beat & owner_q;
        done0           = last_beat & ~owner_q;
        done1           = last_beat & owner_q;
        mem_writeEnable = beat & we_q;
        mem_address     = in_burst ? addr_q : '0;
        mem_inputData   = in_burst ? (owner_q ? wdata1 : wdata0) : '0;
        rvalid0         = rvalid0_q;
        rvalid1         = rvalid1_q;
        rdata           = rdata_q;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        count_d   = count_q;
        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        // On a tie the port not served last wins.
        pick      = (req0 & req1) ? ~last_q : req1;
        len_sel   = pick ? len1 : len0;

        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    owner_d = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = pick ? addr1 : addr0;
                    count_d = (len_sel == '0) ? OneBeat : len_sel;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (beat) begin
                    addr_d  = (addr_q == LastAddr) ? '0 : addr_q + ADDRESS_WIDTH'(1);
                    count_d = count_q - OneBeat;
                    if (!we_q) begin
                        rdata_d   = mem_outputData;
                        rvalid0_d = ~owner_q;
                        rvalid1_d = owner_q;
                    end
                    if (count_q == OneBeat) begin
                        state_d = StIdle;
                        last_d  = owner_q;
                    end
                end else begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Bench for vector_memory_arbiter: behavioural memory, scoreboard of expected beats and read
// returns, and scenario tasks for reads, wrapping writes, arbitration, aborts and resets.
module tb_vector_memory_arbiter;

    localparam int AW  = 19;
    localparam int DW  = 64;
    localparam int BW  = 4;
    localparam int MSZ = 2000;
    localparam logic [63:0] Pat = 64'h5A00_0000_0000_0000;

    typedef struct {
        int          port;
        bit          we;
        int          addr;
        logic [63:0] data;
        bit          done;
    } beat_t;

    typedef struct {
        int          port;
        logic [63:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] len0, len1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_writeEnable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_inputData, mem_outputData;

    logic [63:0] tb_mem [0:MSZ-1];
    logic        pl_init, pl_we;
    int          pl_addr;
    logic [63:0] pl_data;
    logic [63:0] wcnt0 = '0, wcnt1 = '0, wofs0 = '0, wofs1 = '0;

    beat_t exp_beat[$];
    rd_t   exp_rd[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    vector_memory_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BURST_WIDTH  (BW),
        .MEM_SIZE     (MSZ)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .len0           (len0),
        .len1           (len1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .done0          (done0),
        .done1          (done1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata          (rdata),
        .mem_writeEnable(mem_writeEnable),
        .mem_address    (mem_address),
        .mem_inputData  (mem_inputData),
        .mem_outputData (mem_outputData)
    );

    assign mem_outputData = (int'(mem_address) < MSZ) ? tb_mem[mem_address] : '0;
    assign wdata0 = wofs0 + wcnt0;
    assign wdata1 = wofs1 + wcnt1;

    always @(posedge clk) begin
        if (pl_init) begin
            for (int i = 0; i < MSZ; i++) tb_mem[i] <= Pat | 64'(i);
        end else if (pl_we) begin
            tb_mem[pl_addr] <= pl_data;
        end else if (mem_writeEnable && int'(mem_address) < MSZ) begin
            tb_mem[mem_address] <= mem_inputData;
        end
        if (gnt0) wcnt0 <= wcnt0 + 64'd1;
        if (gnt1) wcnt1 <= wcnt1 + 64'd1;
    end

    // Scoreboard: every beat and every read return is matched against the queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt0 || gnt1) begin
                beat_t b;
                total++;
                if (exp_beat.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got gnt=%b%b addr=%0d want no beat",
                             gnt1, gnt0, mem_address);
                end else begin
                    b = exp_beat.pop_front();
                    if ({gnt1, gnt0} !== ((b.port == 1) ? 2'b10 : 2'b01)) begin
                        bad++;
                        $display("FAIL beat_port: got gnt=%b%b want port %0d", gnt1, gnt0, b.port);
                    end
                    total++;
                    if (mem_address !== AW'(b.addr)) begin
                        bad++;
                        $display("FAIL beat_addr: got %0d want %0d", mem_address, b.addr);
                    end
                    total++;
                    if (mem_writeEnable !== b.we) begin
                        bad++;
                        $display("FAIL beat_we: got %b want %b", mem_writeEnable, b.we);
                    end
                    total++;
                    if ({done1, done0} !== (b.done ? ((b.port == 1) ? 2'b10 : 2'b01) : 2'b00)) begin
                        bad++;
                        $display("FAIL beat_done: got %b%b want done=%b port %0d",
                                 done1, done0, b.done, b.port);
                    end
                    if (b.we) begin
                        total++;
                        if (mem_inputData !== b.data) begin
                            bad++;
                            $display("FAIL beat_wdata: got %h want %h", mem_inputData, b.data);
                        end
                    end
                end
            end else begin
                total++;
                if ({done1, done0, mem_writeEnable} !== 3'b000) begin
                    bad++;
                    $display("FAIL idle_strobes: got done=%b%b we=%b want 000",
                             done1, done0, mem_writeEnable);
                end
            end
            if (rvalid0 || rvalid1) begin
                rd_t r;
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected: got rvalid=%b%b rdata=%h want none",
                             rvalid1, rvalid0, rdata);
                end else begin
                    r = exp_rd.pop_front();
                    if ({rvalid1, rvalid0} !== ((r.port == 1) ? 2'b10 : 2'b01) ||
                        rdata !== r.data) begin
                        bad++;
                        $display("FAIL rdata: got rvalid=%b%b data=%h want port %0d data=%h",
                                 rvalid1, rvalid0, rdata, r.port, r.data);
                    end
                end
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [63:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clk);
        #1;
        pl_we   = 1'b0;
    endtask

    // Drives one burst from the current (mid-cycle) time; returns what it observed.
    task automatic do_burst(input int port, input bit we, input int addr, input int len,
                            input logic [63:0] first, input int drop_after,
                            output int beats, output int dones, output int lat);
        int    n, eff, a;
        beat_t b;
        n   = (len == 0) ? 1 : len;
        eff = (drop_after < n) ? drop_after : n;
        a   = addr;
        for (int i = 0; i < eff; i++) begin
            b.port = port; b.we = we; b.addr = a; b.data = first + 64'(i);
            b.done = (i == n - 1);
            exp_beat.push_back(b);
            if (!we) exp_rd.push_back('{port, tb_mem[a]});
            a = (a == MSZ - 1) ? 0 : a + 1;
        end
        if (port == 0) begin
            we0 = we; addr0 = AW'(addr); len0 = BW'(len); wofs0 = first - wcnt0; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = AW'(addr); len1 = BW'(len); wofs1 = first - wcnt1; req1 = 1'b1;
        end
        beats = 0; dones = 0; lat = -1;
        for (int cyc = 1; cyc <= 40 && beats < eff; cyc++) begin
            @(negedge clk);
            if ((port == 0) ? gnt0 : gnt1) begin
                beats++;
                if (lat < 0) lat = cyc;
            end
            if ((port == 0) ? done0 : done1) dones++;
        end
        @(posedge clk);
        #1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0; pl_init = 0; pl_we = 0;
        pl_addr = 0; pl_data = '0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, done0, done1, rvalid0, rvalid1, mem_writeEnable} !== 7'b0 ||
            rdata !== '0 || mem_address !== '0 || mem_inputData !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b%b rdata=%h addr=%0d want all zero",
                     gnt1, gnt0, rdata, mem_address);
        end
        #1;
        pl_init = 1'b1;
        @(posedge clk);
        #1;
        pl_init = 1'b0;
        preload(5, 64'hA);
        preload(6, 64'hB);
        preload(7, 64'hC);
        sync();
        reset = 1'b0;
    endtask

    task automatic do_reset();
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        sync();
        sync();
        total++;
        if (exp_beat.size() != 0 || exp_rd.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got beats=%0d reads=%0d outstanding want 0",
                     name, exp_beat.size(), exp_rd.size());
        end
        exp_beat.delete();
        exp_rd.delete();
    endtask

    task automatic test_single_read();
        int b, d, l;
        sync();
        do_burst(0, 1'b0, 5, 3, '0, 99, b, d, l);
        total++;
        if (b != 3 || d != 1 || l != 1) begin
            bad++;
            $display("FAIL single_read: got beats=%0d done=%0d lat=%0d want 3 1 1", b, d, l);
        end
        check_drained("single_read");
    endtask

    task automatic test_write_wrap();
        int b, d, l;
        sync();
        do_burst(1, 1'b1, 1998, 4, 64'd1, 99, b, d, l);
        total++;
        if (b != 4 || d != 1 || l != 1) begin
            bad++;
            $display("FAIL write_wrap: got beats=%0d done=%0d lat=%0d want 4 1 1", b, d, l);
        end
        sync();
        total++;
        if (tb_mem[1998] !== 64'd1 || tb_mem[1999] !== 64'd2 ||
            tb_mem[0] !== 64'd3 || tb_mem[1] !== 64'd4) begin
            bad++;
            $display("FAIL write_wrap_mem: got %0d %0d %0d %0d want 1 2 3 4",
                     tb_mem[1998], tb_mem[1999], tb_mem[0], tb_mem[1]);
        end
        do_burst(1, 1'b0, 1998, 4, '0, 99, b, d, l);
        total++;
        if (b != 4 || d != 1) begin
            bad++;
            $display("FAIL wrap_readback: got beats=%0d done=%0d want 4 1", b, d);
        end
        check_drained("write_wrap");
    endtask

    task automatic test_round_robin();
        logic [21:0] seq;
        int          pa [4] = '{0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                int a;
                a = (pa[k] == 0 ? 100 : 200) + i;
                exp_beat.push_back('{pa[k], 1'b0, a, '0, (i == 1)});
                exp_rd.push_back('{pa[k], tb_mem[a]});
            end
        end
        seq = '0;
        we0 = 0; addr0 = AW'(100); len0 = BW'(2);
        we1 = 0; addr1 = AW'(200); len1 = BW'(2);
        req0 = 1'b1; req1 = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            seq = {seq[19:0], gnt1, gnt0};
        end
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (seq !== 22'b01_01_00_10_10_00_01_01_00_10_10) begin
            bad++;
            $display("FAIL round_robin_seq: got %b want 0101001010000101001010", seq);
        end
        check_drained("round_robin");
    endtask

    task automatic test_len_zero();
        int b, d, l;
        sync();
        do_burst(0, 1'b0, 10, 0, '0, 99, b, d, l);
        total++;
        if (b != 1 || d != 1 || l != 1) begin
            bad++;
            $display("FAIL len_zero: got beats=%0d done=%0d lat=%0d want 1 1 1", b, d, l);
        end
        check_drained("len_zero");
    endtask

    task automatic test_abort();
        int b, d, l, lat0;
        sync();
        we0 = 0; addr0 = AW'(300); len0 = BW'(1); req0 = 1'b1;
        do_burst(1, 1'b1, 500, 8, 64'h77_0000, 3, b, d, l);
        exp_beat.push_back('{0, 1'b0, 300, '0, 1'b1});
        exp_rd.push_back('{0, tb_mem[300]});
        lat0 = -1;
        for (int cyc = 1; cyc <= 10 && lat0 < 0; cyc++) begin
            @(negedge clk);
            if (gnt0) lat0 = cyc;
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        total++;
        if (b != 3 || d != 0 || l != 1) begin
            bad++;
            $display("FAIL abort_beats: got beats=%0d done=%0d lat=%0d want 3 0 1", b, d, l);
        end
        total++;
        if (lat0 != 3) begin
            bad++;
            $display("FAIL abort_next_grant: got cycle %0d want 3", lat0);
        end
        total++;
        if (tb_mem[500] !== 64'h77_0000 || tb_mem[501] !== 64'h77_0001 ||
            tb_mem[502] !== 64'h77_0002 || tb_mem[503] !== (Pat | 64'd503)) begin
            bad++;
            $display("FAIL abort_mem: got %h %h %h %h want 770000 770001 770002 untouched",
                     tb_mem[500], tb_mem[501], tb_mem[502], tb_mem[503]);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid_burst();
        int b, d, l;
        sync();
        exp_beat.push_back('{0, 1'b1, 700, 64'hDEAD_0001, 1'b0});
        we0 = 1; addr0 = AW'(700); len0 = BW'(5); wofs0 = 64'hDEAD_0001 - wcnt0; req0 = 1'b1;
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL midrst_first_beat: got gnt0=%b want 1", gnt0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({gnt0, gnt1, done0, done1, rvalid0, rvalid1, mem_writeEnable} !== 7'b0 ||
            rdata !== '0 || mem_address !== '0 || mem_inputData !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got gnt=%b%b we=%b rdata=%h want all zero",
                     gnt1, gnt0, mem_writeEnable, rdata);
        end
        req0 = 1'b0;
        sync();
        sync();
        reset = 1'b0;
        total++;
        if (tb_mem[700] !== 64'hDEAD_0001 || tb_mem[701] !== (Pat | 64'd701)) begin
            bad++;
            $display("FAIL midrst_mem: got %h %h want DEAD0001 and untouched",
                     tb_mem[700], tb_mem[701]);
        end
        sync();
        do_burst(0, 1'b0, 700, 2, '0, 99, b, d, l);
        total++;
        if (b != 2 || d != 1 || l != 1) begin
            bad++;
            $display("FAIL midrst_recover: got beats=%0d done=%0d lat=%0d want 2 1 1", b, d, l);
        end
        check_drained("reset_mid_burst");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wrap();
        test_round_robin();
        test_len_zero();
        test_abort();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
